// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding and bus constants for the CPU/DMA bus arbiter
package bus_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_OWN0 = 2'd1, ARB_OWN1 = 2'd2} arb_state_t;
  localparam int BUS_ADDR_W = 25;
  localparam int BUS_DATA_W = 32;
  localparam logic [BUS_DATA_W-1:0] BUS_TIMEOUT_RDATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: per-access wait counter and saturating count of forced terminations
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       ready,
  output logic       expire,
  output logic [7:0] timeout_count
);
  logic [7:0] wait_cnt;
  assign expire = enable && !ready && wait_cnt == 8'(TIMEOUT_CYCLES - 1);
  // wait counter restarts every idle cycle; timeout total saturates at 255
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt      <= '0;
      timeout_count <= '0;
    end else begin
      wait_cnt <= clear ? 8'd0 : (enable && !ready) ? wait_cnt + 8'd1 : wait_cnt;
      if (expire && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
    end
  end
endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: round-robin CPU/DMA arbiter for the system bus with access timeout
module cpu_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_valid,
  input  logic [BUS_ADDR_W-1:0] m0_address,
  input  logic [3:0]            m0_wstrb,
  input  logic [BUS_DATA_W-1:0] m0_wdata,
  output logic                  m0_ready,
  output logic [BUS_DATA_W-1:0] m0_rdata,
  input  logic                  m1_valid,
  input  logic [BUS_ADDR_W-1:0] m1_address,
  input  logic [3:0]            m1_wstrb,
  input  logic [BUS_DATA_W-1:0] m1_wdata,
  output logic                  m1_ready,
  output logic [BUS_DATA_W-1:0] m1_rdata,
  output logic                  bus_valid,
  output logic [BUS_ADDR_W-1:0] bus_address,
  output logic [3:0]            bus_wstrb,
  output logic [BUS_DATA_W-1:0] bus_wdata,
  input  logic                  bus_ready,
  input  logic [BUS_DATA_W-1:0] bus_rdata,
  output logic                  timeout_pulse,
  output logic [7:0]            timeout_count
);
  arb_state_t state;
  logic last, own, sel1, fin, pick1, expire;
  logic [BUS_DATA_W-1:0] fin_rdata;
  assign own       = state != ARB_IDLE;
  assign sel1      = state == ARB_OWN1;
  assign fin       = own && (bus_ready || expire);
  assign pick1     = (m0_valid && m1_valid) ? !last : m1_valid;
  assign fin_rdata = bus_ready ? bus_rdata : BUS_TIMEOUT_RDATA;
  assign m0_ready  = fin && !sel1;
  assign m1_ready  = fin && sel1;
  assign m0_rdata  = m0_ready ? fin_rdata : '0;
  assign m1_rdata  = m1_ready ? fin_rdata : '0;
  assign timeout_pulse = expire;
  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (!own),
    .enable       (own),
    .ready        (bus_ready),
    .expire       (expire),
    .timeout_count(timeout_count)
  );
  // grant from IDLE latching the winner's request, release to IDLE on completion or timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ARB_IDLE;
      last        <= 1'b1;
      bus_valid   <= 1'b0;
      bus_address <= '0;
      bus_wstrb   <= '0;
      bus_wdata   <= '0;
    end else if (state == ARB_IDLE) begin
      if (m0_valid || m1_valid) begin
        state       <= pick1 ? ARB_OWN1 : ARB_OWN0;
        bus_valid   <= 1'b1;
        bus_address <= pick1 ? m1_address : m0_address;
        bus_wstrb   <= pick1 ? m1_wstrb : m0_wstrb;
        bus_wdata   <= pick1 ? m1_wdata : m0_wdata;
      end
    end else if (fin) begin
      state     <= ARB_IDLE;
      bus_valid <= 1'b0;
      last      <= sel1;
    end
  end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed and randomized checks against a transaction-level model
module tb_cpu_bus_arbiter;
  localparam int T = 15;
  logic clk = 1'b0, reset_n;
  logic m0_valid, m1_valid, m0_ready, m1_ready, bus_valid, bus_ready, timeout_pulse;
  logic [24:0] m0_address, m1_address, bus_address;
  logic [3:0] m0_wstrb, m1_wstrb, bus_wstrb;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, bus_wdata, bus_rdata;
  logic [7:0] timeout_count;
  int errors = 0, checks = 0;
  int last_m = 1, tcnt = 0;

  cpu_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_address(m0_address), .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_address(m1_address), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .bus_valid(bus_valid), .bus_address(bus_address), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .timeout_pulse(timeout_pulse), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus_valid, 0);
    chk({tag, "_fields"}, {bus_address, bus_wstrb, bus_wdata}, 0);
    chk({tag, "_ready"}, {m0_ready, m1_ready}, 0);
    chk({tag, "_pulse"}, timeout_pulse, 0);
    chk({tag, "_count"}, timeout_count, 0);
  endtask

  // Called at a negedge in an idle cycle with master requests already driven.
  // lat = bus cycle in which the slave answers (> T means never).
  task automatic access(input int lat, input logic [31:0] rd, input bit hold);
    int w;
    logic [24:0] ea;
    logic [3:0] es;
    logic [31:0] ed, er;
    bit done, tmo;
    w  = (m0_valid && m1_valid) ? 1 - last_m : (m1_valid ? 1 : 0);
    ea = w ? m1_address : m0_address;
    es = w ? m1_wstrb : m0_wstrb;
    ed = w ? m1_wdata : m0_wdata;
    bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    #1;
    chk("idle_bus_valid", bus_valid, 0);
    chk("idle_ready", {m0_ready, m1_ready}, 0);
    @(negedge clk);
    for (int c = 1; c <= T; c++) begin
      bus_ready = (c == lat);
      bus_rdata = (c == lat) ? rd : $urandom;
      #1;
      done = (c == lat) || (c == T);
      tmo  = (c == T) && (c != lat);
      er   = (c == lat) ? rd : 32'hFFFF_FFFF;
      chk("own_bus_valid", bus_valid, 1);
      chk("bus_fields", {bus_address, bus_wstrb, bus_wdata}, {ea, es, ed});
      chk("win_ready", w ? m1_ready : m0_ready, done);
      chk("win_rdata", w ? m1_rdata : m0_rdata, done ? er : 32'h0);
      chk("lose_ready_rdata", w ? {m0_ready, m0_rdata} : {m1_ready, m1_rdata}, 0);
      chk("timeout_pulse", timeout_pulse, tmo);
      if (done) begin
        last_m = w;
        if (tmo && tcnt < 255) tcnt++;
        break;
      end
      @(negedge clk);
    end
    if (!hold) begin
      if (w) m1_valid = 1'b0;
      else m0_valid = 1'b0;
    end
    @(negedge clk);
    bus_ready = 1'($urandom_range(0, 1));
    #1;
    chk("timeout_count", timeout_count, tcnt);
  endtask

  initial begin
    reset_n = 1'b0;
    {m0_valid, m1_valid, bus_ready} = '0;
    {m0_address, m0_wstrb, m0_wdata, m1_address, m1_wstrb, m1_wdata, bus_rdata} = '0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // tie out of reset: CPU, DMA, CPU, DMA
    m0_valid = 1; m0_address = 25'h0000100; m0_wstrb = 4'h0; m0_wdata = 32'h0;
    m1_valid = 1; m1_address = 25'h1ABCDE0; m1_wstrb = 4'hF; m1_wdata = 32'h55AA_1234;
    for (int i = 0; i < 4; i++) access(1 + i, 32'h1000 + i, 1);
    m0_valid = 0; m1_valid = 0;
    @(negedge clk);
    // single CPU read answered on second bus cycle
    m0_valid = 1; m0_address = 25'h0010004; m0_wstrb = 0; m0_wdata = 0;
    access(2, 32'h1234_5678, 0);
    // unmapped read times out
    m0_valid = 1; m0_address = 25'h0090000;
    access(99, 32'h0, 0);
    // slave answers exactly in the timeout cycle
    m0_valid = 1; m0_address = 25'h0090004;
    access(T, 32'hCAFE_F00D, 0);
    // random traffic; a losing master keeps its request pending
    for (int i = 0; i < 40; i++) begin
      if (!m0_valid && $urandom_range(0, 1) == 1) begin
        m0_valid = 1; m0_address = 25'($urandom); m0_wstrb = 4'($urandom); m0_wdata = $urandom;
      end
      if (!m1_valid && $urandom_range(0, 1) == 1) begin
        m1_valid = 1; m1_address = 25'($urandom); m1_wstrb = 4'($urandom); m1_wdata = $urandom;
      end
      if (!m0_valid && !m1_valid) m0_valid = 1;
      access(int'($urandom_range(1, 18)), $urandom, 0);
    end
    m0_valid = 0; m1_valid = 0;
    @(negedge clk);
    // DMA write interrupted by reset
    bus_ready = 0;
    m1_valid = 1; m1_address = 25'h0123456; m1_wstrb = 4'b0011; m1_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    #1;
    chk("dma_grant", {bus_valid, bus_wstrb, bus_wdata}, {1'b1, 4'b0011, 32'hAABB_CCDD});
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    m1_valid = 0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("reset_hold_ready", {m0_ready, m1_ready, bus_valid}, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    last_m = 1; tcnt = 0;
    m0_valid = 1; m0_address = 25'h0000040; m0_wstrb = 0;
    access(3, 32'h0BAD_BEEF, 0);
    // saturation of the timeout counter
    for (int i = 0; i < 300; i++) begin
      m0_valid = 1; m0_address = 25'($urandom);
      access(99, 32'h0, 0);
    end
    chk("count_saturated", timeout_count, 8'd255);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Two-master arbiter sharing the single system bus that feeds the address decoder. Master 0 is the CPU, master 1 is the DMA/copper master. Each master uses a valid/ready handshake. The block grants the bus round-robin, holds the grant until the slave completes, and terminates unanswered accesses (unmapped decode regions) with a bus timeout.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 15: cycles a granted access may wait for `bus_ready` before forced termination; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_valid  in  1  CPU request; held with its fields until `m0_ready`
- m0_address  in  25  CPU byte address
- m0_wstrb  in  4  CPU write strobes; 0 = read
- m0_wdata  in  32  CPU write data
- m0_ready  out  1  CPU access complete (one-cycle pulse)
- m0_rdata  out  32  CPU read data, valid when `m0_ready`
- m1_valid, m1_address, m1_wstrb, m1_wdata  in  1/25/4/32  DMA request; same rules as m0
- m1_ready  out  1  DMA access complete
- m1_rdata  out  32  DMA read data
- bus_valid  out  1  request to address decoder
- bus_address  out  25  granted address
- bus_wstrb  out  4  granted strobes
- bus_wdata  out  32  granted write data
- bus_ready  in  1  slave completion
- bus_rdata  in  32  slave read data
- timeout_pulse  out  1  one-cycle pulse on forced termination
- timeout_count  out  8  saturating count of timeouts since reset

## Operation

- States: IDLE, OWN0, OWN1. Round-robin pointer `last` (0/1) records the master served most recently.
- IDLE:
  - Only m0_valid: go to OWN0.
  - Only m1_valid: go to OWN1.
  - Both valid: grant the master that is not `last`.
  - On grant, register the winner's address, wstrb and wdata onto the bus_* outputs, and set bus_valid = 1.
- OWNx: bus_valid stays 1 and bus_* fields stay frozen. Master inputs are not re-sampled.
- Normal completion: when bus_ready = 1 in OWNx:
  - mx_ready = 1 and mx_rdata = bus_rdata, combinationally in the same cycle.
  - Next edge: bus_valid = 0, `last` = x, state = IDLE.
- Timeout: a wait counter clears on grant and increments each OWNx cycle with bus_ready = 0. In the cycle where the counter equals TIMEOUT_CYCLES-1 and bus_ready = 0:
  - mx_ready = 1 and mx_rdata = 32'hFFFF_FFFF.
  - timeout_pulse = 1.
  - timeout_count increments, saturating at 255.
  - Next edge: IDLE, `last` = x.
- If bus_ready arrives in the same cycle as the timeout condition, normal completion wins: no pulse, no count.
- The non-granted mx_ready is always 0. mx_rdata is 0 whenever mx_ready is 0.
- bus_ready seen in IDLE is ignored.
- A write uses the same flow; rdata content is don't-care for the master.

## Timing

- Reset values (asserted asynchronously, held while reset_n = 0):
  - state = IDLE, `last` = 1 (so the CPU wins the first tie).
  - bus_valid = 0; bus_address, bus_wstrb, bus_wdata = 0.
  - m0_ready = m1_ready = 0, timeout_pulse = 0, timeout_count = 0.
- Grant latency: a request sampled at edge N produces bus_valid high from edge N+1.
- Minimum access is 3 cycles per master transaction: grant cycle, bus cycle with ready, return to IDLE.
- There is always at least one IDLE cycle between grants. This guarantees a master that drops valid after ready is not re-granted.
- Reset mid-transaction: bus_valid drops immediately and asynchronously, with no ready pulse to either master. The pending access is lost; masters are reset by the same reset_n.

## Structure

- Shared package `bus_arb_pkg`:
  - state encoding constants ARB_IDLE, ARB_OWN0, ARB_OWN1;
  - BUS_TIMEOUT_RDATA = 32'hFFFF_FFFF;
  - width constants BUS_ADDR_W = 25, BUS_DATA_W = 32.
- One sub-module: `bus_timeout_counter`. It holds the wait counter and the saturating timeout_count, with inputs clear/enable/ready and output `expire`. Everything else stays in the top module.

## Test plan

- Single CPU read, 0x0010004, slave ready on 2nd bus cycle with rdata 0x12345678 -> bus_valid high from edge+1; m0_rdata = 0x12345678 with a one-cycle m0_ready; returns to IDLE.
- m0_valid and m1_valid asserted simultaneously out of reset, both held for 4 transactions -> grants alternate CPU, DMA, CPU, DMA; each grant is preceded by one IDLE cycle.
- CPU read to unmapped 0x0090000, bus_ready never asserted, TIMEOUT_CYCLES = 15 -> m0_ready on the 15th OWN0 cycle; m0_rdata = 0xFFFF_FFFF; timeout_pulse for 1 cycle; timeout_count = 1.
- bus_ready asserted exactly in the timeout cycle -> normal completion with slave rdata; timeout_pulse = 0; timeout_count unchanged.
- DMA write, wstrb 4'b0011, data 0xAABBCCDD, with reset_n pulled low during OWN1 -> bus_valid = 0 immediately with no clock edge; m1_ready never pulses; all outputs hold reset values; after release, a new CPU request is granted normally.
- 300 consecutive timeouts -> timeout_count saturates at 255; timeout_pulse continues to fire on each.
